// File: rtl/sipo_deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer controller.
package sipo_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam int DEFAULT_NBITS = 8;

endpackage

// File: rtl/sipo_sreg.sv
// NBITS-wide serial-in/parallel-out shift register, MSB arrives first.
module sipo_sreg #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [NBITS-1:0] pout
);

    logic [NBITS-1:0] sreg_q;
    logic [NBITS-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (clr) begin
            sreg_d = '0;
        end else if (en) begin
            sreg_d = {sreg_q[NBITS-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign pout = sreg_q;

endmodule

// File: rtl/sipo_deser_ctrl.sv
// Framed serial-to-parallel deserializer controller with val/rdy on both sides.
// Define SIPO_DESER_PARITY_EN to expect a trailing even-parity bit and flag errors on out_perr.
module sipo_deser_ctrl
    import sipo_deser_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_bit,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic             out_perr
);

    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_rdy_q, in_rdy_d;
    logic             out_val_q, out_val_d;
    logic             sreg_clr;
    logic             sreg_en;
    logic [NBITS-1:0] sreg;
    logic             in_xfer;
    logic             out_xfer;
`ifdef SIPO_DESER_PARITY_EN
    logic             perr_q, perr_d;
`endif

    assign in_xfer  = in_val && in_rdy_q;
    assign out_xfer = out_val_q && out_rdy;

    // in_rdy/out_val are registered, so they change together with the state they describe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_rdy_d  = in_rdy_q;
        out_val_d = out_val_q;
        sreg_clr  = 1'b0;
        sreg_en   = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_xfer && in_bit) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    sreg_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (in_xfer) begin
                    sreg_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
`ifdef SIPO_DESER_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = HOLD;
                        in_rdy_d  = 1'b0;
                        out_val_d = 1'b1;
`endif
                    end
                end
            end
`ifdef SIPO_DESER_PARITY_EN
            PARITY: begin
                if (in_xfer) begin
                    state_d   = HOLD;
                    in_rdy_d  = 1'b0;
                    out_val_d = 1'b1;
                    perr_d    = (^sreg) ^ in_bit;
                end
            end
`endif
            HOLD: begin
                if (out_xfer) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    in_rdy_d  = 1'b1;
                    out_val_d = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
                    perr_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                in_rdy_d  = 1'b1;
                out_val_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
`ifdef SIPO_DESER_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    sipo_sreg #(
        .NBITS (NBITS)
    ) u_sreg (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (sreg_clr),
        .en      (sreg_en),
        .sin     (in_bit),
        .pout    (sreg)
    );

    assign in_rdy   = in_rdy_q;
    assign out_val  = out_val_q;
    assign out_data = sreg;
`ifdef SIPO_DESER_PARITY_EN
    assign out_perr = perr_q;
`else
    assign out_perr = 1'b0;
`endif

endmodule

// File: doc/sipo_deser_ctrl.md
Name: sipo_deser_ctrl

Overview:
- Sequencing controller for an N-bit serial-in/parallel-out shift register.
- Accepts a framed serial bit stream over a val/rdy handshake (start bit, then NBITS data bits, MSB first), drives the shift-enable of an internal SIPO, and presents the assembled word on a val/rdy output port.
- Sits between a serial link front-end and byte-wide consumers.
- Applies backpressure to the serial side while a completed word is unaccepted.

Parameters:
NBITS, 8, data bits per frame (legal range 2..32)

Ports:
clk  input  1  clock; all state updates on posedge clk
reset_n  input  1  synchronous active-low reset
in_val  input  1  serial bit valid
in_rdy  output  1  controller can accept a serial bit this cycle
in_bit  input  1  serial bit value
out_val  output  1  assembled word valid
out_rdy  input  1  consumer accepts word
out_data  output  NBITS  assembled word
out_perr  output  1  parity error flag for the presented word (see Optional Feature)

Behaviour:
- Transfer rules:
  - An input transfer occurs when in_val && in_rdy at posedge clk.
  - An output transfer occurs when out_val && out_rdy.
- FSM states are IDLE, SHIFT, (PARITY when the macro is defined), HOLD.
- Reset (reset_n==0 at posedge): state=IDLE, bit counter=0, SIPO cleared to 0, out_val=0, out_perr=0, out_data=0. Reset mid-frame or mid-HOLD discards the partial or pending word; no output transfer occurs.
- IDLE:
  - in_rdy=1, out_val=0.
  - An input transfer with in_bit==1 is the start bit: go to SHIFT, counter=0, SIPO cleared.
  - An input transfer with in_bit==0 is an idle bit: consumed and ignored.
- SHIFT:
  - in_rdy=1.
  - Each input transfer shifts: sreg <= {sreg[NBITS-2:0], in_bit}, and counter increments.
  - On the transfer with counter==NBITS-1, go to HOLD (or PARITY).
  - Cycles with in_val==0 leave all state unchanged; gaps between bits are unlimited.
- HOLD:
  - in_rdy=0 and out_val=1.
  - out_data=sreg, held stable until the output transfer.
  - On the output transfer, go to IDLE.
  - out_val rises the cycle after the last data bit is transferred.
- Throughput and backpressure:
  - Minimum frame period is NBITS+2 cycles: start + NBITS bits + one HOLD cycle with out_rdy=1.
  - in_bit is never sampled while in_rdy==0.
  - No simultaneous input and output transfers are possible; this is guaranteed by in_rdy==0 in HOLD.
- Counter width is $clog2(NBITS+1). Counter arithmetic never wraps within a frame.
- out_data outside HOLD is sreg (don't-care for consumers). The verifier checks it only when out_val==1.

Optional Feature:
- Macro: SIPO_DESER_PARITY_EN.
- Defined:
  - After the last data bit, SHIFT goes to PARITY (in_rdy=1).
  - The next input transfer is the even-parity bit.
  - HOLD is entered with out_perr = (^sreg) ^ parity_bit.
  - out_perr is valid with out_val and cleared on exit from HOLD.
  - Minimum frame period is NBITS+3.
- Undefined:
  - No PARITY state exists.
  - out_perr is tied to 0.

Decomposition:
- Package sipo_deser_pkg holds:
  - state enum typedef (IDLE, SHIFT, PARITY, HOLD; 2-bit encoding)
  - constant DEFAULT_NBITS=8
- One sub-module, sipo_sreg:
  - parameterised NBITS shift register with clk, reset_n, clr, en, sin, pout.
  - the controller drives clr and en.
- FSM and counter live in sipo_deser_ctrl.

Test Plan:
- Reset then hold: reset_n=0 for 2 cycles, then idle 5 cycles with in_val=1, in_bit=0 -> in_rdy=1, out_val=0, out_data=0 throughout.
- Basic frame: start=1, then bits 1,0,1,0,0,1,0,1 back-to-back with out_rdy=1 -> out_val=1 exactly one cycle after the last bit, out_data=8'hA5; state returns to IDLE next cycle.
- Input gaps: frame 8'h3C with in_val deasserted for 3 cycles between bits 2/3 and bits 6/7 -> out_data=8'h3C; in_val=0 cycles cause no shifts.
- Backpressure: frame 8'hF0 with out_rdy=0 for 4 cycles -> out_val stays 1, out_data stable 8'hF0, in_rdy=0 with in_val=1 and in_bit toggling; deassert-then-assert out_rdy gives a single transfer, after which in_rdy=1.
- Reset mid-frame: after start + 4 bits (1,1,1,1) assert reset_n=0 one cycle, then send full frame 8'h81 -> out_data=8'h81 with no stale bits, and only one out_val pulse.
- Parity (SIPO_DESER_PARITY_EN): frame 8'hA5 + parity 0 -> out_perr=0; frame 8'hA5 + parity 1 -> out_perr=1; out_data=8'hA5 in both cases.
